// File: rtl/imem_loader_if.sv
// Byte-stream handshake carrying a program image into the instruction-memory loader.
`ifndef BITNESS
`define BITNESS 16
`endif

interface imem_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program into the instruction RAM, zero-fills
// the remainder and then releases the processor, serving fetches combinationally.
`ifndef BITNESS
`define BITNESS 16
`endif

module imem_loader #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic                clk,
   input  logic                rst,
   imem_loader_if.slave        rx,
   input  logic                reload,
   input  logic [`BITNESS-1:0] pc,
   output logic [15:0]         ins,
   output logic                cpu_rst,
   output logic                load_done,
   output logic                load_err
);

   typedef enum logic [2:0] {
      HDR_LO, HDR_HI, DATA_LO, DATA_HI, FILL, RUN, ERR
   } state_t;

   localparam logic [15:0] DEPTH16 = 16'(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

   // Output flags packed as {rx_ready, cpu_rst, load_done, load_err}.
   function automatic logic [3:0] flags(input state_t s);
      return {(s == HDR_LO) || (s == HDR_HI) || (s == DATA_LO) || (s == DATA_HI),
              s != RUN, s == RUN, s == ERR};
   endfunction

   state_t      state;
   logic [3:0]  flg;
   logic [AW:0] addr;
   logic [AW:0] n;
   logic [7:0]  n_lo;
   logic [7:0]  lo;
   logic [15:0] hdr;
   logic        accept;
   logic        we;
   logic [15:0] wdata;

   logic [15:0] mem [DEPTH];

   assign rx.rx_ready = flg[3];
   assign cpu_rst     = flg[2];
   assign load_done   = flg[1];
   assign load_err    = flg[0];

   assign accept = rx.rx_valid && rx.rx_ready;
   assign hdr    = {rx.rx_data, n_lo};

   // Reset wins over any write that would otherwise land on the same edge.
   always_comb begin
      we    = 1'b0;
      wdata = '0;
      if (!rst) begin
         if (state == FILL) begin
            we = 1'b1;
         end else if (state == DATA_HI && accept) begin
            we    = 1'b1;
            wdata = {rx.rx_data, lo};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr[AW-1:0]] <= wdata;
   end

   assign ins = mem[pc[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HDR_LO;
         flg   <= flags(HDR_LO);
         addr  <= '0;
         n     <= '0;
         n_lo  <= '0;
         lo    <= '0;
      end else begin
         case (state)
            HDR_LO: if (accept) begin
               n_lo  <= rx.rx_data;
               state <= HDR_HI;
               flg   <= flags(HDR_HI);
            end
            HDR_HI: if (accept) begin
               addr <= '0;
               if (hdr > DEPTH16) begin
                  state <= ERR;
                  flg   <= flags(ERR);
               end else begin
                  n <= hdr[AW:0];
                  if (hdr == 16'd0) begin
                     state <= FILL;
                     flg   <= flags(FILL);
                  end else begin
                     state <= DATA_LO;
                     flg   <= flags(DATA_LO);
                  end
               end
            end
            DATA_LO: if (accept) begin
               lo    <= rx.rx_data;
               state <= DATA_HI;
               flg   <= flags(DATA_HI);
            end
            DATA_HI: if (accept) begin
               addr <= addr + 1'b1;
               if (addr == n - 1'b1) begin
                  if (n < DEPTH_W) begin
                     state <= FILL;
                     flg   <= flags(FILL);
                  end else begin
                     state <= RUN;
                     flg   <= flags(RUN);
                  end
               end else begin
                  state <= DATA_LO;
                  flg   <= flags(DATA_LO);
               end
            end
            FILL: begin
               addr <= addr + 1'b1;
               if (addr == LAST_W) begin
                  state <= RUN;
                  flg   <= flags(RUN);
               end
            end
            RUN, ERR: if (reload) begin
               state <= HDR_LO;
               flg   <= flags(HDR_LO);
               addr  <= '0;
            end
            default: begin
               state <= HDR_LO;
               flg   <= flags(HDR_LO);
               addr  <= '0;
            end
         endcase
      end
   end

   logic unused_pc;
   assign unused_pc = ^pc[`BITNESS-1:AW];

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected RAM words are queued as the stream is sent
// and popped when the RAM is read back through pc/ins.
`ifndef BITNESS
`define BITNESS 16
`endif

module tb_imem_loader;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic                clk = 1'b0;
   logic                rst;
   logic                reload;
   logic [`BITNESS-1:0] pc;
   logic [15:0]         ins;
   logic                cpu_rst, load_done, load_err;

   imem_loader_if rx_if ();

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx_if.slave),
      .reload    (reload),
      .pc        (pc),
      .ins       (ins),
      .cpu_rst   (cpu_rst),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] prog_q [$];
   logic [15:0] exp_q  [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int k;
      int w;
      if (gaps) begin
         k = $urandom_range(0, 2);
         if (k != 0) begin
            rx_if.rx_valid = 1'b0;
            repeat (k) tick();
         end
      end
      w = 0;
      while (!rx_if.rx_ready && w < 20) begin
         tick();
         w++;
      end
      if (!rx_if.rx_ready) chk("ready_timeout", 32'(rx_if.rx_ready), 32'd1);
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      tick();
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask

   task automatic load(input bit gaps);
      int n;
      int cyc;
      int rdy_seen;
      logic [15:0] w;
      if (load_done) begin
         pulse_reload();
         chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
         chk("reload_rx_ready", 32'(rx_if.rx_ready), 32'd1);
         chk("reload_done", 32'(load_done), 32'd0);
      end
      n = prog_q.size();
      send_byte(8'(n), gaps);
      send_byte(8'(n >> 8), gaps);
      foreach (prog_q[i]) begin
         w = prog_q[i];
         send_byte(w[7:0], gaps);
         send_byte(w[15:8], gaps);
         exp_q.push_back(w);
      end
      // Keep offering junk while the loader is not ready; none of it may land.
      rx_if.rx_data  = 8'hEE;
      rx_if.rx_valid = gaps;
      chk("ready_low_after_last", 32'(rx_if.rx_ready), 32'd0);
      cyc = 0;
      rdy_seen = 0;
      while (!load_done && cyc < 2000) begin
         if (rx_if.rx_ready) rdy_seen++;
         tick();
         cyc++;
      end
      chk($sformatf("fill_edges_n%0d", n), 32'(cyc), 32'(DEPTH - n));
      chk("run_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("ready_in_fill", 32'(rdy_seen), 32'd0);
      repeat (5) tick();
      chk("run_hold_done", 32'(load_done), 32'd1);
      chk("run_hold_ready", 32'(rx_if.rx_ready), 32'd0);
      rx_if.rx_valid = 1'b0;
      for (int i = n; i < DEPTH; i++) exp_q.push_back(16'h0000);
      for (int a = 0; a < DEPTH; a++) begin
         pc = `BITNESS'(a);
         #1;
         chk($sformatf("mem[%0d]", a), 32'(ins), 32'(exp_q.pop_front()));
      end
      pc = '0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      reload = 1'b0;
      pc = '0;
      rx_if.rx_data = 8'h00;
      rx_if.rx_valid = 1'b0;
      repeat (2) tick();
      chk("rst_rx_ready", 32'(rx_if.rx_ready), 32'd1);
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      rst = 1'b0;

      // Nominal back-to-back three-word program.
      prog_q = '{16'h1234, 16'h5678, 16'h9ABC};
      load(1'b0);
      pc = `BITNESS'(1);
      #1;
      chk("pc1_ins", 32'(ins), 32'h5678);
      pc = '0;
      tick();

      // Same program with random gaps and junk held during FILL/RUN.
      load(1'b1);

      // Oversize header N=1025 goes straight to ERR.
      pulse_reload();
      send_byte(8'h01, 1'b0);
      send_byte(8'h04, 1'b0);
      rx_if.rx_valid = 1'b0;
      chk("err_load_err", 32'(load_err), 32'd1);
      chk("err_rx_ready", 32'(rx_if.rx_ready), 32'd0);
      chk("err_cpu_rst", 32'(cpu_rst), 32'd1);
      pulse_reload();
      chk("err_reload_err", 32'(load_err), 32'd0);
      chk("err_reload_ready", 32'(rx_if.rx_ready), 32'd1);
      prog_q = '{16'hA5A5};
      load(1'b0);

      // Empty program: full zero fill.
      prog_q.delete();
      load(1'b0);

      // Full program: no fill cycles at all.
      for (int i = 0; i < DEPTH; i++) prog_q.push_back(16'($urandom));
      load(1'b0);

      // Reset in the middle of a load; reload in a loading state must be ignored.
      pulse_reload();
      send_byte(8'h04, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      rx_if.rx_valid = 1'b0;
      pulse_reload();
      chk("ign_reload_ready", 32'(rx_if.rx_ready), 32'd1);
      chk("ign_reload_err", 32'(load_err), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 32'(rx_if.rx_ready), 32'd1);
      chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("midrst_done", 32'(load_done), 32'd0);
      prog_q = '{16'h1111, 16'h2222};
      load(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory stage that sits directly upstream of `processor`. It receives a program as a little-endian byte stream over a valid/ready handshake and writes it into a 1024×16 instruction RAM. It then zero-fills the rest of the RAM and releases the processor from reset. Once running, it serves `ins = mem[pc[9:0]]` combinationally, so the processor's fetch sees the instruction in the same cycle as `pc`.

## Interface
Parameters:
- `DEPTH`, 1024: instruction words in the RAM; must be a power of two.
- `AW`, 10: address bits; `DEPTH == 2**AW`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming program byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `reload`  in  1  single-cycle pulse; restarts loading from the RUN or ERR state.
- `pc`  in  `` `BITNESS ``  processor program counter; only `pc[AW-1:0]` is used.
- `ins`  out  16  `mem[pc[AW-1:0]]`, combinational (asynchronous) read.
- `cpu_rst`  out  1  reset to `processor`; high in every state except RUN.
- `load_done`  out  1  high only in RUN.
- `load_err`  out  1  high only in ERR.

## Operation
- A byte is accepted on a rising edge where `rx_valid && rx_ready`. No other byte transfer exists.
- Stream format:
  - Header: 2 bytes, word count N, low byte first.
  - Body: N words, 2 bytes each, low byte first. The word is `{hi, lo}`.
- State machine: HDR_LO → HDR_HI → (DATA_LO ↔ DATA_HI) → FILL → RUN, with ERR as a side state.
  - HDR_LO: accept byte and latch `n[7:0]`.
  - HDR_HI: accept byte and form N.
    - If N > DEPTH → ERR.
    - Else if N == 0 → FILL with addr = 0.
    - Else → DATA_LO with addr = 0.
  - DATA_LO: accept byte and latch `lo`.
  - DATA_HI: accept byte and write `mem[addr] <= {byte, lo}`.
    - If addr == N−1 → FILL if N < DEPTH, else RUN.
    - Otherwise addr++ and return to DATA_LO.
  - FILL: write `mem[addr] <= 0` every cycle and increment addr. After writing addr == DEPTH−1 → RUN.
  - RUN: steady state. `reload` → HDR_LO.
  - ERR: stalled. `reload` → HDR_LO.
- `reload` is ignored in every state except RUN and ERR.
- addr and N are AW+1 bits wide, so N = DEPTH is representable. N is compared as an unsigned 16-bit value.
- `rx_ready` is 1 in HDR_LO, HDR_HI, DATA_LO and DATA_HI, and 0 in FILL, RUN and ERR. Bytes offered while `rx_ready` is 0 are not consumed.
- `cpu_rst`, `load_done` and `load_err` are pure decodes of the state register, so they are glitch-free.
- `ins` reads the array at all times. During loading its value is don't-care, because the processor is held in reset.

## Timing
- Reset values, on the edge where `rst` = 1:
  - state = HDR_LO, addr = 0.
  - `rx_ready` = 1, `cpu_rst` = 1, `load_done` = 0, `load_err` = 0.
  - The RAM contents are not reset.
- Reset mid-operation, from any state: the same reset values apply on that edge. Words already written keep their values, and the next load overwrites all of them.
- Write latency: a RAM write occurs on the same edge that accepts the DATA_HI byte. The new word is visible on `ins` immediately after that edge.
- End of load:
  - With N < DEPTH, RUN is entered exactly DEPTH−N edges after the edge that accepts the last body byte. `cpu_rst` falls on that edge.
  - With N == DEPTH, RUN is entered on the edge that accepts the last body byte.
- Reload: a `reload` edge in RUN or ERR enters HDR_LO. On that edge `cpu_rst` rises, and `rx_ready` is 1 from that edge on.
- Simultaneous events: `rst` has priority over `reload` and over byte acceptance.
- Minimum load time: with back-to-back bytes, 2 + 2N + (DEPTH−N) cycles from reset release.

## Test plan
- Nominal load, back-to-back: stream `03 00 34 12 78 56 BC 9A`.
  - Required: `mem[0..2]` = 1234, 5678, 9ABC (hex) and `mem[3..1023]` = 0.
  - `rx_ready` is 0 from the edge after the last byte.
  - `cpu_rst` falls and `load_done` rises exactly 1021 edges after the last byte is accepted.
  - With pc = 1, `ins` = 5678.
- Backpressure and gaps: same stream with `rx_valid` randomly deasserted, and extra bytes held on `rx_data` while in FILL/RUN.
  - Required: identical RAM contents, and no extra byte is consumed in FILL or RUN.
- Oversize header: stream `01 04` (N = 1025).
  - Required: ERR on the next edge, with `load_err` = 1, `rx_ready` = 0, `cpu_rst` = 1.
  - A 1-cycle `reload` then gives `load_err` = 0 and `rx_ready` = 1. A following valid load completes normally.
- Empty and full programs:
  - N = 0 (`00 00`): RUN after 1024 FILL cycles, with every word 0.
  - N = 1024 (`00 04` + 2048 bytes): RUN on the edge of the last byte, with no FILL cycles.
- Reset mid-load: assert `rst` for 1 cycle after 5 accepted bytes.
  - Required: HDR_LO, addr = 0, `cpu_rst` = 1.
  - A fresh `02 00 11 11 22 22` then loads 1111 and 2222 at addresses 0 and 1, with the rest 0.
- End to end with `processor`: load a program whose last instruction sets `pin_out[1]`.
  - Required: the processor leaves reset only after `load_done`, `pc` starts at 0, and `pin_out[1]` asserts before `pc` exceeds the program length.
